// File: rtl/seg_pkg.sv
// Shared constants and sizing helpers for the 7-segment scan driver.
// Segment codes are active-high with bit 0 = a through bit 6 = g.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n is the glyph for nibble n (0-9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int calc_div(input int clk_freq, input int scan_freq);
        return clk_freq / scan_freq;
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_rom.sv
// Hex nibble to active-high 7-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module seg_hex_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    assign code = SEG_CODES[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit 7-segment scan driver: shadowed hex digits time-multiplexed onto a shared segment bus.
// Latency: outputs registered one cycle after dwell counter/digit index; shadow changes visible next cycle.
// Backpressure: none; free-running scan, the update strobe is always accepted.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS     = 6,
    parameter  int CLK_FREQ       = 50_000_000,
    parameter  int SCAN_FREQ      = 1000,
    parameter  int BLANK_CYCLES   = 2,
    parameter  int SEG_ACTIVE_LOW = 1,
    parameter  int SEL_ACTIVE_LOW = 1,
    localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] disp_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    update,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic [7:0]              seg_data,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int DIV   = calc_div(CLK_FREQ, SCAN_FREQ);
    localparam int CNT_W = cnt_width(DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_INV   = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]            SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [4*NUM_DIGITS-1:0] disp_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic                    lz_sh;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    // upper_clear[i]: every digit above i is zero or masked, so a zero at i is leading.
    logic [NUM_DIGITS-1:0]   upper_clear;
    logic [3:0]              cur_nib;
    logic                    cur_dp_raw;
    logic                    cur_blank;
    logic                    cur_upper;
    logic                    cur_dark;
    logic [6:0]              rom_code;
    logic [6:0]              cur_code;
    logic [7:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   cur_sel;

    always_comb begin
        upper_clear = '0;
        upper_clear[NUM_DIGITS-1] = 1'b1;
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_clear[i] = upper_clear[i+1]
                           & ((disp_sh[4*(i+1) +: 4] == 4'h0) | blank_sh[i+1]);
        end
    end

    always_comb begin
        cur_nib    = 4'h0;
        cur_dp_raw = 1'b0;
        cur_blank  = 1'b0;
        cur_upper  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = disp_sh[4*i +: 4];
                cur_dp_raw = dp_sh[i];
                cur_blank  = blank_sh[i];
                cur_upper  = upper_clear[i];
            end
        end
    end

    seg_hex_rom u_rom (
        .nibble (cur_nib),
        .code   (rom_code)
    );

    // Digit 0 always shows, so a value of zero still reads "0".
    assign cur_dark = cur_blank
                    | (lz_sh & (idx != '0) & (cur_nib == 4'h0) & cur_upper);
    assign cur_code = cur_dark ? SEG_OFF : rom_code;
    assign cur_seg  = {cur_dp_raw & ~cur_blank, cur_code};
    assign cur_sel  = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sh   <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            lz_sh     <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            seg_sel   <= SEL_INV;
            seg_data  <= SEG_INV;
            digit_idx <= '0;
        end else begin
            if (update) begin
                disp_sh  <= disp_data;
                dp_sh    <= dp_in;
                blank_sh <= blank_mask;
                lz_sh    <= lz_suppress;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Anti-ghost gap: everything dark while the select lines settle.
            if (cnt < CNT_BLANK) begin
                seg_sel  <= SEL_INV;
                seg_data <= SEG_INV;
            end else begin
                seg_sel  <= cur_sel ^ SEL_INV;
                seg_data <= cur_seg ^ SEG_INV;
            end
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: active-high and active-low builds share one stimulus (DIV=10, 4 digits).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] disp_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_suppress = 1'b0;
    logic        update = 1'b0;

    logic [3:0]  sel_h, sel_l;
    logic [7:0]  data_h, data_l;
    logic [1:0]  idx_h, idx_l;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_FREQ(40), .SCAN_FREQ(4), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) dut_h (
        .clk(clk), .rst(rst), .disp_data(disp_data), .dp_in(dp_in),
        .blank_mask(blank_mask), .lz_suppress(lz_suppress), .update(update),
        .seg_sel(sel_h), .seg_data(data_h), .digit_idx(idx_h)
    );

    seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_FREQ(40), .SCAN_FREQ(4), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut_l (
        .clk(clk), .rst(rst), .disp_data(disp_data), .dp_in(dp_in),
        .blank_mask(blank_mask), .lz_suppress(lz_suppress), .update(update),
        .seg_sel(sel_l), .seg_data(data_l), .digit_idx(idx_l)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] data;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;
    logic        m_lz = 1'b0;

    logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [7:0] model_seg(input int i);
        logic       dark;
        logic       lead;
        logic [3:0] nib;
        nib  = m_disp[4*i +: 4];
        dark = m_blank[i];
        if (m_lz && i != 0 && nib == 4'h0) begin
            lead = 1'b1;
            for (int j = i + 1; j < 4; j++)
                if (m_disp[4*j +: 4] != 4'h0 && !m_blank[j]) lead = 1'b0;
            if (lead) dark = 1'b1;
        end
        return {m_dp[i] & ~m_blank[i], dark ? 7'h00 : codes[nib]};
    endfunction

    // Push the expected post-edge outputs, advance the reference, then cross the edge.
    task automatic tick();
        exp_t x;
        if (rst) begin
            x.sel = '0; x.data = '0; x.idx = '0;
            m_cnt = 0; m_idx = 0;
            m_disp = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
        end else begin
            x.idx = 2'(m_idx);
            if (m_cnt < 2) begin
                x.sel = '0; x.data = '0;
            end else begin
                x.sel  = 4'b0001 << m_idx;
                x.data = model_seg(m_idx);
            end
            if (update) begin
                m_disp = disp_data; m_dp = dp_in; m_blank = blank_mask; m_lz = lz_suppress;
            end
            if (m_cnt == 9) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = exp_q.pop_front(); n_chk++;
            if ({sel_h, data_h, idx_h, sel_l, data_l, idx_l} !== {e.sel, e.data, e.idx, ~e.sel, ~e.data, e.idx})
                $display("FAIL reset k=%0d got h=%h/%h/%0d l=%h/%h/%0d want h=%h/%h/%0d",
                         k, sel_h, data_h, idx_h, sel_l, data_l, idx_l, e.sel, e.data, e.idx);
            else n_pass++;
        end
        n_chk++;
        if (sel_l !== 4'hF || data_l !== 8'hFF || sel_h !== 4'h0 || data_h !== 8'h00)
            $display("FAIL reset_levels got l=%h/%h h=%h/%h want l=f/ff h=0/00", sel_l, data_l, sel_h, data_h);
        else n_pass++;
    endtask

    task automatic test_scan();
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            e = exp_q.pop_front(); n_chk++;
            if ({sel_h, data_h, idx_h, sel_l, data_l, idx_l} !== {e.sel, e.data, e.idx, ~e.sel, ~e.data, e.idx})
                $display("FAIL scan k=%0d got h=%h/%h/%0d l=%h/%h/%0d want h=%h/%h/%0d",
                         k, sel_h, data_h, idx_h, sel_l, data_l, idx_l, e.sel, e.data, e.idx);
            else n_pass++;
            if (k == 1 || k == 2 || k == 12 || k == 42) begin
                n_chk++;
                if (sel_h !== ((k == 1) ? 4'b0000 : (k == 12) ? 4'b0010 : 4'b0001))
                    $display("FAIL scan_sel k=%0d got %b", k, sel_h);
                else n_pass++;
            end
        end
    endtask

    typedef struct {
        logic [15:0] disp;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [31:0] want;
    } pat_t;

    task automatic test_display_patterns();
        pat_t       pats [6];
        logic [7:0] obs [4];
        pats[0] = '{16'hFEDC, 4'b0000, 4'b0000, 1'b0, 32'h71795E39};
        pats[1] = '{16'h3210, 4'b0000, 4'b0000, 1'b0, 32'h4F5B063F};
        pats[2] = '{16'h0070, 4'b0000, 4'b0000, 1'b1, 32'h0000073F};
        pats[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h0000003F};
        pats[4] = '{16'h1234, 4'b0101, 4'b0100, 1'b0, 32'h06004FE6};
        pats[5] = '{16'h5003, 4'b0010, 4'b1000, 1'b1, 32'h0000804F};
        for (int p = 0; p < 6; p++) begin
            for (int d = 0; d < 4; d++) obs[d] = 8'hXX;
            for (int k = 0; k < 42; k++) begin
                update = (k == 0);
                if (k == 0) begin
                    disp_data = pats[p].disp; dp_in = pats[p].dp;
                    blank_mask = pats[p].blank; lz_suppress = pats[p].lz;
                end
                tick();
                e = exp_q.pop_front(); n_chk++;
                if ({sel_h, data_h, idx_h, sel_l, data_l, idx_l} !== {e.sel, e.data, e.idx, ~e.sel, ~e.data, e.idx})
                    $display("FAIL pattern%0d k=%0d got h=%h/%h/%0d l=%h/%h/%0d want h=%h/%h/%0d",
                             p, k, sel_h, data_h, idx_h, sel_l, data_l, idx_l, e.sel, e.data, e.idx);
                else n_pass++;
                if (k >= 1 && sel_h != 4'b0000) obs[idx_h] = data_h;
            end
            update = 1'b0;
            for (int d = 0; d < 4; d++) begin
                n_chk++;
                if (obs[d] !== pats[p].want[8*d +: 8])
                    $display("FAIL pattern%0d_digit%0d got %h want %h", p, d, obs[d], pats[p].want[8*d +: 8]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int rst_at = -1;
        for (int k = 0; k < 80; k++) begin
            if (rst_at < 0 && m_idx == 2 && m_cnt == 4) begin
                rst = 1'b1;
                rst_at = k;
            end else begin
                rst = 1'b0;
            end
            tick();
            e = exp_q.pop_front(); n_chk++;
            if ({sel_h, data_h, idx_h, sel_l, data_l, idx_l} !== {e.sel, e.data, e.idx, ~e.sel, ~e.data, e.idx})
                $display("FAIL rst_mid k=%0d got h=%h/%h/%0d l=%h/%h/%0d want h=%h/%h/%0d",
                         k, sel_h, data_h, idx_h, sel_l, data_l, idx_l, e.sel, e.data, e.idx);
            else n_pass++;
            if (rst_at >= 0 && k == rst_at) begin
                n_chk++;
                if (sel_h !== 4'h0 || data_h !== 8'h00 || idx_h !== 2'd0 || sel_l !== 4'hF || data_l !== 8'hFF)
                    $display("FAIL rst_mid_outputs got h=%h/%h/%0d l=%h/%h", sel_h, data_h, idx_h, sel_l, data_l);
                else n_pass++;
            end
            if (rst_at >= 0 && k == rst_at + 3) begin
                n_chk++;
                if (data_h !== 8'h3F || sel_h !== 4'b0001)
                    $display("FAIL rst_mid_shadow got %h/%b want 3f/0001", data_h, sel_h);
                else n_pass++;
            end
        end
        rst = 1'b0;
        n_chk++;
        if (rst_at < 0) $display("FAIL rst_mid_reach got no digit-2 dwell want one within 80 cycles");
        else n_pass++;
    endtask

    task automatic test_update_mid_dwell();
        for (int k = 0; k < 14; k++) begin
            rst    = (k == 0);
            update = (k == 1) || (k == 6);
            if (k == 1) begin
                disp_data = 16'h0008; dp_in = '0; blank_mask = '0; lz_suppress = 1'b0;
            end
            if (k == 6) disp_data = 16'h0001;
            tick();
            e = exp_q.pop_front(); n_chk++;
            if ({sel_h, data_h, idx_h, sel_l, data_l, idx_l} !== {e.sel, e.data, e.idx, ~e.sel, ~e.data, e.idx})
                $display("FAIL upd_mid k=%0d got h=%h/%h/%0d l=%h/%h/%0d want h=%h/%h/%0d",
                         k, sel_h, data_h, idx_h, sel_l, data_l, idx_l, e.sel, e.data, e.idx);
            else n_pass++;
            if (k == 6 || k == 7 || k == 10 || k == 11) begin
                n_chk++;
                if ({sel_l, data_l} !== ((k == 6)  ? 12'hE80 :
                                         (k == 11) ? 12'hFFF : 12'hEF9))
                    $display("FAIL upd_mid_lit k=%0d got sel=%b data=%h", k, sel_l, data_l);
                else n_pass++;
            end
        end
        update = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_display_patterns();
        test_reset_mid_scan();
        test_update_mid_dwell();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
